// File: rtl/debouncer_dois_botoes_if.sv
// Raw button inputs and debounced outputs of the two-button debouncer.
// No handshake: raw levels are sampled every clock, and every output is a registered level or a one-cycle pulse.
interface debouncer_dois_botoes_if;
   logic botao1_bruto;
   logic botao2_bruto;
   logic pino2;
   logic pino3;
   logic press1;
   logic press2;
   logic solta1;
   logic solta2;
   // Per-channel debug state: 0 = ESTAVEL, 1 = QUALIFICANDO.
   logic estado1;
   logic estado2;

   modport master (
      output botao1_bruto, botao2_bruto,
      input  pino2, pino3, press1, press2, solta1, solta2, estado1, estado2
   );

   modport slave (
      input  botao1_bruto, botao2_bruto,
      output pino2, pino3, press1, press2, solta1, solta2, estado1, estado2
   );
endinterface

// File: rtl/debouncer_dois_botoes.sv
// Two independent button debouncers: a 2-flop synchronizer, a stability counter,
// a registered level and one-cycle press/release pulses per channel.
module debouncer_dois_botoes #(
   parameter int N_ESTAVEL   = 16,
   parameter bit ATIVO_BAIXO = 1'b0
) (
   input logic clk,
   input logic rst,
   debouncer_dois_botoes_if.slave bus
);

   localparam int CW = (N_ESTAVEL > 1) ? $clog2(N_ESTAVEL) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(N_ESTAVEL - 1);

   typedef enum logic {ESTAVEL = 1'b0, QUALIFICANDO = 1'b1} estado_t;

   logic [1:0]    bruto;
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    nivel;
   logic [1:0]    nivel_n;
   logic [1:0]    press;
   logic [1:0]    press_n;
   logic [1:0]    solta;
   logic [1:0]    solta_n;
   logic [CW-1:0] cnt   [2];
   logic [CW-1:0] cnt_n [2];
   estado_t       estado [2];

   // Index 0 is button 1 (pino2), index 1 is button 2 (pino3).
   assign bruto = {bus.botao2_bruto, bus.botao1_bruto} ^ {2{ATIVO_BAIXO}};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         nivel <= '0;
         press <= '0;
         solta <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         s1    <= bruto;
         s2    <= s1;
         nivel <= nivel_n;
         press <= press_n;
         solta <= solta_n;
         for (int i = 0; i < 2; i++) cnt[i] <= cnt_n[i];
      end
   end

   // A single cycle of agreement between s2 and the level drops back to ESTAVEL
   // and clears the counter, so a bounce restarts qualification from zero.
   always_comb begin
      nivel_n = nivel;
      press_n = '0;
      solta_n = '0;
      for (int i = 0; i < 2; i++) begin
         cnt_n[i]  = '0;
         estado[i] = (s2[i] != nivel[i]) ? QUALIFICANDO : ESTAVEL;
         case (estado[i])
            ESTAVEL: begin
               cnt_n[i] = '0;
            end
            QUALIFICANDO: begin
               if (cnt[i] == CNT_MAX) begin
                  nivel_n[i] = s2[i];
                  cnt_n[i]   = '0;
                  press_n[i] = s2[i];
                  solta_n[i] = ~s2[i];
               end else begin
                  cnt_n[i] = cnt[i] + CW'(1);
               end
            end
            default: begin
               cnt_n[i] = '0;
            end
         endcase
      end
   end

   assign bus.pino2   = nivel[0];
   assign bus.pino3   = nivel[1];
   assign bus.press1  = press[0];
   assign bus.press2  = press[1];
   assign bus.solta1  = solta[0];
   assign bus.solta2  = solta[1];
   assign bus.estado1 = estado[0];
   assign bus.estado2 = estado[1];

endmodule

// File: tb/tb_debouncer_dois_botoes.sv
// Bench for debouncer_dois_botoes: a non-inverted and an inverted instance driven side by side,
// checked against a sample-window model through an expected-output queue.
module tb_debouncer_dois_botoes;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   debouncer_dois_botoes_if bus_a ();
   debouncer_dois_botoes_if bus_b ();

   debouncer_dois_botoes #(.N_ESTAVEL(N), .ATIVO_BAIXO(1'b0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   debouncer_dois_botoes #(.N_ESTAVEL(N), .ATIVO_BAIXO(1'b1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   int errors = 0;
   int checks = 0;

   // Vector: [11]pino3 [10]pino2 [9]press2 [8]press1 [7]solta2 [6]solta1 of instance a, [5:0] same for b.
   logic [11:0] exp_q[$];

   // Model: a channel changes level at an edge when its last N synchronized samples all differ from it.
   logic [N:0] hist [4];
   logic [3:0] lvl;

   // Per-phase observations.
   int          cyc;
   int          rise_a2, rise_a3, fall_a2, rise_b2;
   int          n_press1, n_press2, n_solta1, n_pulses, n_coinc, n_pino3_hi;
   logic [11:0] prev_v;
   logic [11:0] first_v;
   string       cur_tag;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] model_edge(input logic [3:0] b);
      logic [3:0] p;
      logic [3:0] s;
      p = '0;
      s = '0;
      for (int c = 0; c < 4; c++) begin
         if (rst) begin
            hist[c] = '0;
            lvl[c]  = 1'b0;
         end else begin
            if (hist[c][N:1] == {N{~lvl[c]}}) begin
               lvl[c] = ~lvl[c];
               p[c]   = lvl[c];
               s[c]   = ~lvl[c];
            end
            hist[c] = {hist[c][N-1:0], b[c]};
         end
      end
      return {lvl[1], lvl[0], p[1], p[0], s[1], s[0], lvl[3], lvl[2], p[3], p[2], s[3], s[2]};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {bus_a.pino3, bus_a.pino2, bus_a.press2, bus_a.press1, bus_a.solta2, bus_a.solta1,
              bus_b.pino3, bus_b.pino2, bus_b.press2, bus_b.press1, bus_b.solta2, bus_b.solta1};
   endfunction

   task automatic clear_obs();
      cyc = 0;
      rise_a2 = 0; rise_a3 = 0; fall_a2 = 0; rise_b2 = 0;
      n_press1 = 0; n_press2 = 0; n_solta1 = 0; n_pulses = 0; n_coinc = 0; n_pino3_hi = 0;
   endtask

   // a1/a2 are raw inputs of instance a, b1/b2 of the inverted instance b.
   task automatic step(input logic a1, input logic a2, input logic b1, input logic b2);
      logic [11:0] got;
      logic [11:0] exp;
      @(negedge clk);
      bus_a.botao1_bruto = a1;
      bus_a.botao2_bruto = a2;
      bus_b.botao1_bruto = b1;
      bus_b.botao2_bruto = b2;
      exp_q.push_back(model_edge({~b2, ~b1, a2, a1}));
      @(posedge clk);
      #1;
      got = dut_vec();
      exp = exp_q.pop_front();
      check(cur_tag, {20'd0, got}, {20'd0, exp});
      cyc++;
      if (cyc == 1) first_v = got;
      if (!prev_v[10] && got[10] && rise_a2 == 0) rise_a2 = cyc;
      if (!prev_v[11] && got[11] && rise_a3 == 0) rise_a3 = cyc;
      if (prev_v[10] && !got[10] && fall_a2 == 0) fall_a2 = cyc;
      if (!prev_v[4] && got[4] && rise_b2 == 0) rise_b2 = cyc;
      if (got[8]) n_press1++;
      if (got[9]) n_press2++;
      if (got[6]) n_solta1++;
      if (got[8] && got[9]) n_coinc++;
      if (got[11]) n_pino3_hi++;
      n_pulses += int'(got[9]) + int'(got[8]) + int'(got[7]) + int'(got[6])
                + int'(got[3]) + int'(got[2]) + int'(got[1]) + int'(got[0]);
      prev_v = got;
   endtask

   initial begin
      logic [7:0] bounce;
      for (int c = 0; c < 4; c++) hist[c] = '0;
      lvl    = '0;
      prev_v = '0;
      first_v = '0;
      bus_a.botao1_bruto = 1'b0;
      bus_a.botao2_bruto = 1'b0;
      bus_b.botao1_bruto = 1'b1;
      bus_b.botao2_bruto = 1'b1;
      clear_obs();

      // Reset with both raw inputs high, then qualification of the held level.
      cur_tag = "t1_reset";
      rst = 1'b1;
      step(1, 1, 1, 1);
      step(1, 1, 1, 1);
      rst = 1'b0;
      clear_obs();
      cur_tag = "t1_cycle";
      for (int i = 0; i < 10; i++) step(1, 1, 1, 1);
      check("t1_first_cycle", {20'd0, first_v}, 32'd0);
      check("t1_rise_pino2", rise_a2, 6);
      check("t1_rise_pino3", rise_a3, 6);
      check("t1_press1", n_press1, 1);
      check("t1_press2", n_press2, 1);
      check("t1_estado", {bus_a.estado2, bus_a.estado1}, 0);
      cur_tag = "t1_release";
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);

      // Clean press and release of button 1.
      clear_obs();
      cur_tag = "t2_press";
      for (int i = 0; i < 10; i++) step(1, 0, 1, 1);
      check("t2_rise_pino2", rise_a2, 6);
      check("t2_press1", n_press1, 1);
      clear_obs();
      cur_tag = "t2_release";
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
      check("t2_fall_pino2", fall_a2, 6);
      check("t2_solta1", n_solta1, 1);
      check("t2_pino3_low", n_pino3_hi, 0);

      // Bounce 1,0,1,1,0,1,1,1 then held: last run of 1s starts on cycle 6, level rises on cycle 11.
      clear_obs();
      cur_tag = "t3_bounce";
      bounce = 8'b1110_1101;
      for (int i = 0; i < 8; i++) step(bounce[i], 0, 1, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 1, 1);
      check("t3_rise_pino2", rise_a2, 11);
      check("t3_press1", n_press1, 1);
      cur_tag = "t3_release";
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);

      // Three-cycle glitch on button 2 must vanish.
      clear_obs();
      cur_tag = "t4_glitch";
      for (int i = 0; i < 3; i++) step(0, 1, 1, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);
      check("t4_pino3_low", n_pino3_hi, 0);
      check("t4_no_pulses", n_pulses, 0);

      // Both buttons rise together.
      clear_obs();
      cur_tag = "t5_both";
      for (int i = 0; i < 10; i++) step(1, 1, 1, 1);
      check("t5_rise_pino2", rise_a2, 6);
      check("t5_rise_pino3", rise_a3, 6);
      check("t5_coincide", n_coinc, 1);
      cur_tag = "t5_release";
      for (int i = 0; i < 10; i++) step(0, 0, 1, 1);

      // Reset after two qualifying cycles; inverted instance held pressed (raw 0) alongside.
      cur_tag = "t6_pre";
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
      rst = 1'b1;
      cur_tag = "t6_reset";
      step(1, 0, 0, 1);
      rst = 1'b0;
      clear_obs();
      cur_tag = "t6_requal";
      for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
      check("t6_rise_pino2", rise_a2, 6);
      check("t6_press1", n_press1, 1);
      check("t6_inv_rise_pino2", rise_b2, 6);

      // Random stimulus, held several cycles at a time, scored by the model.
      cur_tag = "rnd";
      for (int i = 0; i < 40; i++) begin
         logic [3:0] v;
         int hold;
         v = 4'($urandom_range(0, 15));
         hold = $urandom_range(1, 7);
         for (int k = 0; k < hold; k++) step(v[0], v[1], v[2], v[3]);
      end

      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
